// File: rtl/median_window_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Package : median_pkg
// Brief   : Shared state encoding, default geometry and width helpers for the
//           5x5 median window controller.
// Rev     : 1.0  initial release
// ============================================================================
package median_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } ctrl_state_t;

    localparam int DEF_KERNEL_SIZE  = 5;
    localparam int DEF_IMAGE_WIDTH  = 10;
    localparam int DEF_IMAGE_HEIGHT = 10;
    localparam int DEF_PIPE_LATENCY = 3;

    // Never returns 0 so degenerate ranges still give a legal vector width.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/median_window_ctrl_sideband_delay.sv
`default_nettype none
// ============================================================================
// Module : sideband_delay
// Brief  : DEPTH-stage shift register carrying {valid,tuser,tlast} alongside
//          the median core pipeline.
// Rev    : 1.0  initial release
// ============================================================================
module sideband_delay #(
    parameter int DEPTH = 3,
    parameter int WIDTH = 3
) (
    input  logic             i_clk,
    input  logic             i_aresetn,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            stage_q[0] <= '0;
        end else begin
            stage_q[0] <= i_data;
        end
    end

    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge i_clk or negedge i_aresetn) begin
                if (!i_aresetn) begin
                    stage_q[gi] <= '0;
                end else begin
                    stage_q[gi] <= stage_q[gi-1];
                end
            end
        end
    endgenerate

    assign o_data = stage_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/median_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : median_window_ctrl
// Brief  : Frame/line sequencer for the median path: pixel position tracking,
//          in-image window qualification and latency-aligned AXIS sideband.
//          Optional macro MEDIAN_CTRL_LINE_CHECK_EN enables the tlast check.
// Rev    : 1.0  initial release
// ============================================================================
module median_window_ctrl
    import median_pkg::*;
#(
    parameter int KERNEL_SIZE  = DEF_KERNEL_SIZE,
    parameter int IMAGE_WIDTH  = DEF_IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = DEF_IMAGE_HEIGHT,
    parameter int PIPE_LATENCY = DEF_PIPE_LATENCY
) (
    input  logic                                 i_clk,
    input  logic                                 i_aresetn,
    input  logic                                 i_data_valid,
    input  logic                                 i_start_of_frame,
    input  logic                                 i_end_of_line,
    output logic                                 o_win_valid,
    output logic [cnt_width(IMAGE_WIDTH)-1:0]    o_col,
    output logic [cnt_width(IMAGE_HEIGHT)-1:0]   o_row,
    output logic                                 o_busy,
    output logic                                 o_m_tvalid,
    output logic                                 o_m_tuser,
    output logic                                 o_m_tlast,
    output logic                                 o_frame_done,
    output logic                                 o_err_line
);

    localparam int CW = cnt_width(IMAGE_WIDTH);
    localparam int RW = cnt_width(IMAGE_HEIGHT);
    localparam int DW = cnt_width(PIPE_LATENCY + 1);

    localparam logic [CW-1:0] C_COL_LAST = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] C_ROW_LAST = RW'(IMAGE_HEIGHT - 1);
    localparam logic [CW-1:0] C_COL_K1   = CW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] C_ROW_K1   = RW'(KERNEL_SIZE - 1);
    localparam logic [RW-1:0] C_ROW_K2   = RW'(KERNEL_SIZE - 2);
    localparam logic [DW-1:0] C_LAT      = DW'(PIPE_LATENCY);
    localparam logic [DW-1:0] C_LAT_M1   = DW'(PIPE_LATENCY - 1);

    ctrl_state_t   state_q;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          win_valid_q, tuser_q, tlast_q;
    logic          drain_act_q;
    logic [DW-1:0] drain_cnt_q;
    logic          frame_done_q;
    logic [2:0]    sb_out;

    logic          w_sof, w_accept, w_last_col, w_last_row, w_in_win;
    logic [CW-1:0] w_pix_col;
    logic [RW-1:0] w_pix_row;

    // A start-of-frame pixel is always accepted and is by definition pixel (0,0).
    assign w_sof      = i_data_valid & i_start_of_frame;
    assign w_accept   = i_data_valid & (i_start_of_frame | (state_q == FILL) | (state_q == RUN));
    assign w_pix_col  = w_sof ? '0 : col_q;
    assign w_pix_row  = w_sof ? '0 : row_q;
    assign w_last_col = (w_pix_col == C_COL_LAST);
    assign w_last_row = (w_pix_row == C_ROW_LAST);
    assign w_in_win   = w_accept & (w_pix_col >= C_COL_K1) & (w_pix_row >= C_ROW_K1);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (w_accept) begin
            if (w_last_col) begin
                col_d = '0;
                row_d = w_last_row ? '0 : w_pix_row + RW'(1);
            end else begin
                col_d = w_pix_col + CW'(1);
                row_d = w_pix_row;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            state_q      <= IDLE;
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            tuser_q      <= 1'b0;
            tlast_q      <= 1'b0;
            drain_act_q  <= 1'b0;
            drain_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= w_in_win;
            tuser_q      <= w_in_win & (w_pix_col == C_COL_K1) & (w_pix_row == C_ROW_K1);
            tlast_q      <= w_in_win & w_last_col;
            frame_done_q <= 1'b0;

            // Drain tracking runs independently of the state so a new frame may start while it finishes.
            if (w_accept && !w_sof && (state_q == RUN) && w_last_col && w_last_row) begin
                drain_act_q <= 1'b1;
                drain_cnt_q <= '0;
            end else if (drain_act_q) begin
                drain_cnt_q  <= drain_cnt_q + DW'(1);
                frame_done_q <= (drain_cnt_q == C_LAT_M1);
                if (drain_cnt_q == C_LAT) begin
                    drain_act_q <= 1'b0;
                end
            end

            if (w_sof) begin
                state_q <= FILL;
            end else begin
                case (state_q)
                    FILL: if (w_accept && w_last_col && (w_pix_row == C_ROW_K2)) state_q <= RUN;
                    RUN:  if (w_accept && w_last_col && w_last_row) state_q <= DRAIN;
                    DRAIN: if (drain_act_q && (drain_cnt_q == C_LAT)) state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    sideband_delay #(
        .DEPTH (PIPE_LATENCY),
        .WIDTH (3)
    ) u_sideband_delay (
        .i_clk     (i_clk),
        .i_aresetn (i_aresetn),
        .i_data    ({win_valid_q, tuser_q, tlast_q}),
        .o_data    (sb_out)
    );

`ifdef MEDIAN_CTRL_LINE_CHECK_EN
    logic err_q;
    logic w_eol_bad;

    assign w_eol_bad = i_end_of_line != w_last_col;

    always_ff @(posedge i_clk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            err_q <= 1'b0;
        end else if (w_sof) begin
            err_q <= w_eol_bad;
        end else if (w_accept && w_eol_bad) begin
            err_q <= 1'b1;
        end
    end

    assign o_err_line = err_q;
`else
    logic unused_eol;
    assign unused_eol = i_end_of_line;
    assign o_err_line = 1'b0;
`endif

    assign o_win_valid  = win_valid_q;
    assign o_col        = col_q;
    assign o_row        = row_q;
    assign o_busy       = (state_q != IDLE);
    assign o_m_tvalid   = sb_out[2];
    assign o_m_tuser    = sb_out[1];
    assign o_m_tlast    = sb_out[0];
    assign o_frame_done = frame_done_q;

endmodule
`default_nettype wire

// File: tb/tb_median_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_median_window_ctrl
// Brief  : Directed self-checking bench for median_window_ctrl (W=H=10, K=5, LAT=3).
// Rev    : 1.0  initial release
// ============================================================================
module tb_median_window_ctrl;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, sof, eol;
    logic       o_win_valid, o_busy, o_m_tvalid, o_m_tuser, o_m_tlast, o_frame_done, o_err_line;
    logic [3:0] o_col, o_row;

    int total = 0;
    int bad   = 0;

    // Reference position model: next expected pixel index inside the frame.
    int m_pos = 0;
    bit m_act = 1'b0;

    int first_win, first_tv, last_tv, n_tv, n_tl, n_tu, n_done, done_cyc, busy_low, colrow_bad, err_first;
    bit done_tl;
    int tuser_cyc [4];

    always #5 clk = ~clk;

    median_window_ctrl u_dut (
        .i_clk            (clk),
        .i_aresetn        (rst_n),
        .i_data_valid     (valid),
        .i_start_of_frame (sof),
        .i_end_of_line    (eol),
        .o_win_valid      (o_win_valid),
        .o_col            (o_col),
        .o_row            (o_row),
        .o_busy           (o_busy),
        .o_m_tvalid       (o_m_tvalid),
        .o_m_tuser        (o_m_tuser),
        .o_m_tlast        (o_m_tlast),
        .o_frame_done     (o_frame_done),
        .o_err_line       (o_err_line)
    );

    task automatic clear_stats();
        first_win = -1; first_tv = -1; last_tv = -1; n_tv = 0; n_tl = 0; n_tu = 0;
        n_done = 0; done_cyc = -1; busy_low = -1; colrow_bad = 0; err_first = -1; done_tl = 1'b0;
        for (int i = 0; i < 4; i++) tuser_cyc[i] = -1;
    endtask

    // Pixel k is driven at iteration k*stride; samples after edge c are cycle c+1.
    task automatic stream(input int npix, input int stride, input int sof2, input int bad_eol, input int extra);
        int n_iter, k, pcol, cyc;
        bit drv, s;
        clear_stats();
        n_iter = npix * stride + extra;
        for (int c = 0; c < n_iter; c++) begin
            k    = c / stride;
            drv  = (c % stride == 0) && (k < npix);
            s    = drv && (k == 0 || k == sof2);
            pcol = s ? 0 : m_pos % 10;
            valid = drv;
            sof   = s;
            eol   = drv && ((pcol == 9) != (k == bad_eol));
            @(posedge clk); #1;
            cyc = c + 1;
            if (drv && (s || m_act)) begin
                m_pos = s ? 1 : m_pos + 1;
                m_act = 1'b1;
                if (m_pos == 100) begin
                    m_pos = 0;
                    m_act = 1'b0;
                end
            end
            if (o_col !== 4'(m_pos % 10) || o_row !== 4'(m_pos / 10)) colrow_bad++;
            if (o_win_valid && first_win < 0) first_win = cyc;
            if (o_m_tvalid) begin
                n_tv++;
                if (first_tv < 0) first_tv = cyc;
                last_tv = cyc;
                if (o_m_tlast) n_tl++;
                if (o_m_tuser) begin
                    if (n_tu < 4) tuser_cyc[n_tu] = cyc;
                    n_tu++;
                end
            end
            if (o_frame_done) begin
                n_done++;
                done_cyc = cyc;
                done_tl  = o_m_tvalid && o_m_tlast;
            end
            if (!o_busy && n_done > 0 && busy_low < 0) busy_low = cyc;
            if (o_err_line && err_first < 0) err_first = cyc;
        end
        valid = 1'b0; sof = 1'b0; eol = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 5; c++) begin
            valid = c[0]; sof = 1'b1; eol = ~c[0];
            @(posedge clk); #1;
            total++;
            if ({o_win_valid, o_col, o_row, o_busy, o_m_tvalid, o_m_tuser, o_m_tlast, o_frame_done, o_err_line} !== 15'd0) begin
                bad++;
                $display("FAIL reset_outputs cycle %0d: got col=%0d row=%0d busy=%0b tvalid=%0b, want all 0", c, o_col, o_row, o_busy, o_m_tvalid);
            end
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            valid = 1'b1; sof = 1'b0; eol = 1'b0;
            @(posedge clk); #1;
            total++;
            if (o_busy !== 1'b0 || o_col !== 4'd0 || o_win_valid !== 1'b0) begin
                bad++;
                $display("FAIL reset_release_idle: got busy=%0b col=%0d win=%0b, want 0/0/0", o_busy, o_col, o_win_valid);
            end
        end
        valid = 1'b0;
    endtask

    task automatic test_continuous();
        stream(100, 1, -1, -1, 10);
        total++; if (first_win !== 45) begin bad++; $display("FAIL cont_first_win: got %0d want 45", first_win); end
        total++; if (first_tv !== 48 || tuser_cyc[0] !== 48) begin bad++; $display("FAIL cont_first_tv_tuser: got %0d/%0d want 48/48", first_tv, tuser_cyc[0]); end
        total++; if (n_tv !== 36 || n_tl !== 6 || n_tu !== 1) begin bad++; $display("FAIL cont_counts: got tv=%0d tl=%0d tu=%0d want 36/6/1", n_tv, n_tl, n_tu); end
        total++; if (last_tv !== 103 || done_cyc !== 103 || n_done !== 1 || !done_tl) begin bad++; $display("FAIL cont_done: got last_tv=%0d done=%0d n=%0d tl=%0b want 103/103/1/1", last_tv, done_cyc, n_done, done_tl); end
        total++; if (busy_low !== 104) begin bad++; $display("FAIL cont_busy_low: got %0d want 104", busy_low); end
        total++; if (colrow_bad !== 0) begin bad++; $display("FAIL cont_colrow: got %0d wrong samples want 0", colrow_bad); end
        total++; if (o_err_line !== 1'b0) begin bad++; $display("FAIL cont_err_line: got %0b want 0", o_err_line); end
    endtask

    task automatic test_gaps();
        stream(100, 2, -1, -1, 10);
        total++; if (n_tv !== 36 || n_tl !== 6) begin bad++; $display("FAIL gap_counts: got tv=%0d tl=%0d want 36/6", n_tv, n_tl); end
        total++; if (first_tv !== 92 || done_cyc !== 202 || busy_low !== 203) begin bad++; $display("FAIL gap_timing: got tv=%0d done=%0d idle=%0d want 92/202/203", first_tv, done_cyc, busy_low); end
        total++; if (colrow_bad !== 0) begin bad++; $display("FAIL gap_colrow_hold: got %0d wrong samples want 0", colrow_bad); end
    endtask

    task automatic test_idle_no_sof();
        for (int c = 0; c < 5; c++) begin
            valid = 1'b1; sof = 1'b0; eol = (c == 4);
            @(posedge clk); #1;
            total++;
            if (o_col !== 4'd0 || o_row !== 4'd0 || o_win_valid !== 1'b0 || o_busy !== 1'b0) begin
                bad++;
                $display("FAIL idle_ignore: got col=%0d row=%0d win=%0b busy=%0b want 0/0/0/0", o_col, o_row, o_win_valid, o_busy);
            end
        end
        valid = 1'b0;
        stream(100, 1, -1, -1, 6);
        total++; if (tuser_cyc[0] !== 48 || n_tv !== 36 || n_done !== 1) begin bad++; $display("FAIL idle_then_frame: got tuser=%0d tv=%0d done=%0d want 48/36/1", tuser_cyc[0], n_tv, n_done); end
    endtask

    task automatic test_resync();
        stream(157, 1, 57, -1, 10);
        total++; if (n_tv !== 45 || n_tl !== 7) begin bad++; $display("FAIL resync_counts: got tv=%0d tl=%0d want 45/7", n_tv, n_tl); end
        total++; if (n_tu !== 2 || tuser_cyc[0] !== 48 || tuser_cyc[1] !== 105) begin bad++; $display("FAIL resync_tuser: got n=%0d at %0d,%0d want 2 at 48,105", n_tu, tuser_cyc[0], tuser_cyc[1]); end
        total++; if (n_done !== 1 || done_cyc !== 160) begin bad++; $display("FAIL resync_done: got n=%0d at %0d want 1 at 160", n_done, done_cyc); end
        total++; if (colrow_bad !== 0) begin bad++; $display("FAIL resync_colrow: got %0d wrong samples want 0", colrow_bad); end
    endtask

    task automatic test_line_check();
        stream(100, 1, -1, 28, 6);
`ifdef MEDIAN_CTRL_LINE_CHECK_EN
        total++; if (err_first !== 29 || o_err_line !== 1'b1) begin bad++; $display("FAIL line_err_set: got first=%0d now=%0b want 29/1", err_first, o_err_line); end
`else
        total++; if (err_first !== -1 || o_err_line !== 1'b0) begin bad++; $display("FAIL line_err_off: got first=%0d now=%0b want -1/0", err_first, o_err_line); end
`endif
        total++; if (n_tv !== 36 || n_done !== 1) begin bad++; $display("FAIL line_counting: got tv=%0d done=%0d want 36/1", n_tv, n_done); end
        stream(2, 1, -1, -1, 0);
        total++; if (o_err_line !== 1'b0) begin bad++; $display("FAIL line_err_clear: got %0b want 0", o_err_line); end
    endtask

    task automatic test_midframe_reset();
        stream(47, 1, -1, -1, 0);
        rst_n = 1'b0;
        #1;
        m_pos = 0; m_act = 1'b0;
        total++;
        if (o_busy !== 1'b0 || o_win_valid !== 1'b0 || o_col !== 4'd0 || o_m_tvalid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: got busy=%0b win=%0b col=%0d tvalid=%0b want 0", o_busy, o_win_valid, o_col, o_m_tvalid);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        stream(0, 1, -1, -1, 8);
        total++; if (n_tv !== 0 || o_busy !== 1'b0) begin bad++; $display("FAIL midreset_dropped: got tv=%0d busy=%0b want 0/0", n_tv, o_busy); end
    endtask

    initial begin
        valid = 1'b0; sof = 1'b0; eol = 1'b0; rst_n = 1'b0;
        test_reset();
        test_continuous();
        test_gaps();
        test_idle_no_sof();
        test_resync();
        test_line_check();
        test_midframe_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
